// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the RF writeback arbiter.
// Register-file geometry and requester identifiers.
package rf_wb_arbiter_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam int RF_N  = 1 << RF_AW;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PIPE = 2'd1,
    REQ_MDU  = 2'd2,
    REQ_LSU  = 2'd3
  } req_e;

  function automatic logic [RF_N-1:0] onehot(
    input logic [RF_AW-1:0] idx
  );
    logic [RF_N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Outstanding long-latency destination scoreboard.
// Set on issue, cleared on writeback grant; set wins.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [RF_AW-1:0] set_dst,
  input  logic             clr,
  input  logic [RF_AW-1:0] clr_dst,
  output logic [RF_N-1:0]  busy_mask
);

  logic [RF_N-1:0] set_vec;
  logic [RF_N-1:0] clr_vec;
  logic [RF_N-1:0] mask_nxt;

  // x0 never becomes busy; set is applied after clear.
  always_comb begin
    set_vec  = '0;
    clr_vec  = '0;
    if (set && set_dst != '0)
      set_vec = onehot(set_dst);
    if (clr)
      clr_vec = onehot(clr_dst);
    mask_nxt = (busy_mask & ~clr_vec) | set_vec;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_mask <= '0;
    else
      busy_mask <= mask_nxt;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// RF write-port arbiter: pipeline, MDU and LSU share
// one registered write port, yielding to sync writes.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             sync_we,
  input  logic             pipe_we,
  input  logic [RF_AW-1:0] pipe_wR,
  input  logic [RF_DW-1:0] pipe_wD,
  output logic             pipe_stall,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [RF_AW-1:0] mdu_wR,
  input  logic [RF_DW-1:0] mdu_wD,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [RF_AW-1:0] lsu_wR,
  input  logic [RF_DW-1:0] lsu_wD,
  input  logic             iss_set,
  input  logic [RF_AW-1:0] iss_dst,
  output logic [RF_N-1:0]  busy_mask,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_wR,
  output logic [RF_DW-1:0] rf_wD
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  req_e             grant;
  logic             req_pend;
  logic             starved;
  logic             mdu_pick;
  logic             lsu_pick;
  logic             unit_gnt;
  logic [RF_AW-1:0] win_wR;
  logic [RF_DW-1:0] win_wD;

  // rr_ptr=0 prefers MDU; the other unit wins if preferred is idle.
  always_comb begin
    req_pend = mdu_valid || lsu_valid;
    starved  = req_pend && (starve_cnt == LIMIT);
    mdu_pick = mdu_valid && (!rr_ptr || !lsu_valid);
    lsu_pick = lsu_valid && (rr_ptr || !mdu_valid);
  end

  // Priority: sync write, starvation, pipeline, round-robin.
  always_comb begin
    grant      = REQ_NONE;
    pipe_stall = 1'b0;
    if (sync_we) begin
      pipe_stall = pipe_we;
    end else if (starved) begin
      pipe_stall = pipe_we;
      grant      = mdu_pick ? REQ_MDU : REQ_LSU;
    end else if (pipe_we) begin
      grant = REQ_PIPE;
    end else if (mdu_pick) begin
      grant = REQ_MDU;
    end else if (lsu_pick) begin
      grant = REQ_LSU;
    end
    mdu_ready = (grant == REQ_MDU);
    lsu_ready = (grant == REQ_LSU);
    unit_gnt  = mdu_ready || lsu_ready;
  end

  // Winner's write selected for the output register.
  always_comb begin
    win_wR = '0;
    win_wD = '0;
    unique case (grant)
      REQ_PIPE: begin
        win_wR = pipe_wR;
        win_wD = pipe_wD;
      end
      REQ_MDU: begin
        win_wR = mdu_wR;
        win_wD = mdu_wD;
      end
      REQ_LSU: begin
        win_wR = lsu_wR;
        win_wD = lsu_wD;
      end
      default: ;
    endcase
  end

  // Registered write port; x0 consumes the slot with no write.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rf_we <= 1'b0;
      rf_wR <= '0;
      rf_wD <= '0;
    end else if (grant != REQ_NONE) begin
      rf_we <= (win_wR != '0);
      rf_wR <= win_wR;
      rf_wD <= win_wD;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Round-robin pointer and starvation counter.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (unit_gnt) begin
        rr_ptr     <= mdu_ready;
        starve_cnt <= '0;
      end else if (grant == REQ_PIPE && req_pend
                   && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk       (cpu_clk),
    .rst_n     (cpu_rstn),
    .set       (iss_set),
    .set_dst   (iss_dst),
    .clr       (unit_gnt),
    .clr_dst   (win_wR),
    .busy_mask (busy_mask)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter.
// Expected values are hand-computed constants.
module tb_rf_wb_arbiter;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        sync_we;
  logic        pipe_we;
  logic [4:0]  pipe_wR;
  logic [31:0] pipe_wD;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wR;
  logic [31:0] mdu_wD;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_wR;
  logic [31:0] lsu_wD;
  logic        iss_set;
  logic [4:0]  iss_dst;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;

  int n_vec;
  int n_bad;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .sync_we    (sync_we),
    .pipe_we    (pipe_we),
    .pipe_wR    (pipe_wR),
    .pipe_wD    (pipe_wD),
    .pipe_stall (pipe_stall),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_wR     (mdu_wR),
    .mdu_wD     (mdu_wD),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_wR     (lsu_wR),
    .lsu_wD     (lsu_wD),
    .iss_set    (iss_set),
    .iss_dst    (iss_dst),
    .busy_mask  (busy_mask),
    .rf_we      (rf_we),
    .rf_wR      (rf_wR),
    .rf_wD      (rf_wD)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    cpu_rstn  = 1'b0;
    sync_we   = 1'b0;
    pipe_we   = 1'b0;
    pipe_wR   = '0;
    pipe_wD   = '0;
    mdu_valid = 1'b0;
    mdu_wR    = '0;
    mdu_wD    = '0;
    lsu_valid = 1'b0;
    lsu_wR    = '0;
    lsu_wD    = '0;
    iss_set   = 1'b0;
    iss_dst   = '0;
    #12;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_wR", 32'(rf_wR), 32'd0);
    chk("rst_wD", rf_wD, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    cpu_rstn = 1'b1;
    tick();

    // pipeline write
    pipe_we = 1'b1;
    pipe_wR = 5'd5;
    pipe_wD = 32'h1234;
    #1;
    chk("p_stall", 32'(pipe_stall), 32'd0);
    tick();
    chk("p_we", 32'(rf_we), 32'd1);
    chk("p_wR", 32'(rf_wR), 32'd5);
    chk("p_wD", rf_wD, 32'h1234);

    // round-robin MDU, LSU, MDU
    pipe_we   = 1'b0;
    mdu_valid = 1'b1;
    mdu_wR    = 5'd3;
    mdu_wD    = 32'hAAAA;
    lsu_valid = 1'b1;
    lsu_wR    = 5'd4;
    lsu_wD    = 32'hBBBB;
    #1;
    chk("rr0_mrdy", 32'(mdu_ready), 32'd1);
    chk("rr0_lrdy", 32'(lsu_ready), 32'd0);
    tick();
    chk("rr0_wR", 32'(rf_wR), 32'd3);
    chk("rr0_wD", rf_wD, 32'hAAAA);
    chk("rr1_mrdy", 32'(mdu_ready), 32'd0);
    chk("rr1_lrdy", 32'(lsu_ready), 32'd1);
    tick();
    chk("rr1_wR", 32'(rf_wR), 32'd4);
    chk("rr1_wD", rf_wD, 32'hBBBB);
    chk("rr2_mrdy", 32'(mdu_ready), 32'd1);
    tick();
    chk("rr2_wR", 32'(rf_wR), 32'd3);
    lsu_valid = 1'b0;

    // starvation: pipeline wins 4 cycles, then MDU forced
    pipe_we   = 1'b1;
    mdu_wR    = 5'd9;
    mdu_wD    = 32'h9999;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sv_stall", 32'(pipe_stall), 32'd0);
      chk("sv_mrdy", 32'(mdu_ready), 32'd0);
      tick();
      chk("sv_wR", 32'(rf_wR), 32'd5);
    end
    chk("sv5_stall", 32'(pipe_stall), 32'd1);
    chk("sv5_mrdy", 32'(mdu_ready), 32'd1);
    tick();
    chk("sv5_wR", 32'(rf_wR), 32'd9);
    chk("sv5_wD", rf_wD, 32'h9999);
    chk("sv6_stall", 32'(pipe_stall), 32'd0);
    chk("sv6_mrdy", 32'(mdu_ready), 32'd0);
    mdu_valid = 1'b0;
    pipe_we   = 1'b0;
    tick();

    // scoreboard set then clear
    iss_set = 1'b1;
    iss_dst = 5'd7;
    tick();
    iss_set = 1'b0;
    chk("sb_set", busy_mask, 32'h80);
    mdu_valid = 1'b1;
    mdu_wR    = 5'd7;
    mdu_wD    = 32'h7777;
    #1;
    chk("sb_mrdy", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    chk("sb_clr", busy_mask, 32'h0);
    iss_set = 1'b1;
    iss_dst = 5'd0;
    tick();
    chk("sb_x0", busy_mask, 32'h0);
    iss_dst = 5'd7;
    tick();
    chk("sb_set2", busy_mask, 32'h80);
    mdu_valid = 1'b1;
    tick();
    iss_set   = 1'b0;
    mdu_valid = 1'b0;
    chk("sb_setwin", busy_mask, 32'h80);
    chk("sb_wR", 32'(rf_wR), 32'd7);

    // sync write blocks everything
    sync_we   = 1'b1;
    pipe_we   = 1'b1;
    pipe_wR   = 5'd12;
    pipe_wD   = 32'hC0C0;
    lsu_valid = 1'b1;
    lsu_wR    = 5'd6;
    lsu_wD    = 32'h6666;
    #1;
    chk("sy_stall", 32'(pipe_stall), 32'd1);
    chk("sy_lrdy", 32'(lsu_ready), 32'd0);
    tick();
    chk("sy_we", 32'(rf_we), 32'd0);
    chk("sy_hold", 32'(rf_wR), 32'd7);
    sync_we = 1'b0;
    #1;
    chk("sy2_stall", 32'(pipe_stall), 32'd0);
    chk("sy2_lrdy", 32'(lsu_ready), 32'd0);
    tick();
    chk("sy2_we", 32'(rf_we), 32'd1);
    chk("sy2_wR", 32'(rf_wR), 32'd12);

    // LSU write to x0: granted, no RF write
    pipe_we = 1'b0;
    lsu_wR  = 5'd0;
    lsu_wD  = 32'hDEAD;
    #1;
    chk("x0_lrdy", 32'(lsu_ready), 32'd1);
    tick();
    chk("x0_we", 32'(rf_we), 32'd0);

    // async reset mid-grant
    lsu_wR = 5'd8;
    lsu_wD = 32'h8888;
    tick();
    lsu_valid = 1'b0;
    chk("mr_we1", 32'(rf_we), 32'd1);
    chk("mr_busy1", busy_mask, 32'h80);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("mr_we0", 32'(rf_we), 32'd0);
    chk("mr_busy0", busy_mask, 32'h0);
    chk("mr_wR0", 32'(rf_wR), 32'd0);
    #3;
    cpu_rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single RF write port (we/wR/wD) and shares it between three requesters: in-order pipeline writeback, multiply/divide unit (MDU) and load/store unit (LSU) miss returns.
- Keeps a per-register scoreboard of outstanding long-latency destinations for the issue stage's hazard check.
- Yields the port to the inc_dev sync write whenever one is active.
- Sits between the writeback stage and the RF.

Parameters:
- STARVE_LIMIT, 4, consecutive lost cycles a pending MDU/LSU request tolerates before the pipeline is stalled for one cycle (range 1..15).
- CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- cpu_clk  in  1  clock
- cpu_rstn  in  1  asynchronous active-low reset
- sync_we  in  1  inc_dev sync write active this cycle; blocks all grants
- pipe_we  in  1  pipeline writeback request; has no ready and must be accepted unless pipe_stall
- pipe_wR  in  5  pipeline destination
- pipe_wD  in  32  pipeline data
- pipe_stall  out  1  combinational; freezes the writeback stage this cycle
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  combinational grant to MDU
- mdu_wR  in  5  MDU destination
- mdu_wD  in  32  MDU data
- lsu_valid  in  1  LSU result valid
- lsu_ready  out  1  combinational grant to LSU
- lsu_wR  in  5  LSU destination
- lsu_wD  in  32  LSU data
- iss_set  in  1  issue of a long-latency op
- iss_dst  in  5  destination register of that op
- busy_mask  out  32  registered scoreboard; bit n set means xn has a write outstanding
- rf_we  out  1  registered RF write enable
- rf_wR  out  5  registered RF write address
- rf_wD  out  32  registered RF write data

Behaviour:
- Reset (async, cpu_rstn=0): rf_we=0, rf_wR=0, rf_wD=0, busy_mask=0, rr_ptr=0 (MDU first), starve_cnt=0. Combinational outputs follow the rules below from the reset state.
- Handshake: a transfer occurs when valid && ready. Requesters hold wR/wD stable while valid && !ready.
- Priority, evaluated each cycle:
  1. sync_we=1: no grant; mdu_ready=lsu_ready=0; pipe_stall=pipe_we; starve_cnt holds.
  2. starve_cnt==STARVE_LIMIT with an MDU/LSU request pending: pipe_stall=pipe_we and the round-robin winner is granted.
  3. pipe_we=1: pipeline wins and pipe_stall=0.
  4. Otherwise, round-robin between MDU and LSU: rr_ptr selects the preferred unit, and the other is granted if the preferred one is idle.
- Round-robin: after each MDU/LSU grant, rr_ptr points away from the unit just granted. rr_ptr is unchanged on pipeline grants.
- Starvation counter: increments when (mdu_valid||lsu_valid) and the pipeline wins. Resets to 0 on any MDU/LSU grant. Saturates at STARVE_LIMIT.
- Latency: the winner's wR/wD are registered into rf_wR/rf_wD with rf_we=1 on the next cycle, giving 1-cycle grant-to-RF latency.
- With no grant, rf_we=0 next cycle and rf_wR/rf_wD hold.
- Writes to x0 are granted and consume the slot, but rf_we is forced to 0.
- Scoreboard:
  - bit iss_dst is set on iss_set when iss_dst!=0.
  - bit wR is cleared on an MDU/LSU grant (at the grant edge, not the RF edge).
  - Same-cycle set and clear of the same register: set wins.
  - Pipeline grants never touch busy_mask.
- Reset mid-transfer: any granted-but-unwritten result is dropped. Upstream units are reset by the same cpu_rstn.

Decomposition:
- Shared package/header:
  - RF_AW=5, RF_DW=32 constants.
  - Requester ID encoding: REQ_NONE, REQ_PIPE, REQ_MDU, REQ_LSU.
- One natural sub-module, rf_scoreboard: the 32-bit busy_mask with set/clear and set-wins rule, plus reset.
- Arbitration and the output register stay in the top.

Test Plan:
- pipe_we=1, wR=5, wD=0x1234 with no other requests -> pipe_stall=0; the next cycle shows rf_we=1, rf_wR=5, rf_wD=0x1234.
- mdu_valid and lsu_valid both held with pipe idle from reset -> grants alternate MDU, LSU, MDU in three consecutive cycles; rf_wR follows mdu_wR/lsu_wR accordingly.
- pipe_we held 1 and mdu_valid held 1, STARVE_LIMIT=4 -> pipeline wins 4 cycles; 5th cycle pipe_stall=1 and mdu_ready=1; starve_cnt returns to 0.
- iss_set with dst=7, then an MDU transfer with wR=7 -> busy_mask[7] is 1 after issue and 0 the cycle after the grant. Same-cycle iss_set dst=7 with a grant to wR=7 -> busy_mask[7] stays 1.
- sync_we=1 while pipe_we=1 and lsu_valid=1 -> pipe_stall=1, lsu_ready=0, rf_we=0 next cycle. After sync_we drops, the pipeline is granted first.
- lsu_valid with wR=0 -> lsu_ready=1 and rf_we=0 next cycle. Separately, assert cpu_rstn=0 mid-grant -> rf_we=0 and busy_mask=0 immediately, without waiting for a clock edge.
